max_result_tx: RTL and testbench

//  Read-out end of the peak-capture path: takes the latched peak position/value pair on each

---
 rtl/max_result_tx_pkg.sv | 38 +++
 rtl/max_result_tx_if.sv | 23 ++
 rtl/max_result_tx.sv | 147 ++++++++++++++
 tb/tb_max_result_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max_result_tx_pkg.sv
// Shared types and frame layout for the peak-result UART transmitter.
// frame_byte() is the single place that defines the six-byte frame contents.
package max_tx_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Frame layout: sync, pos[8], pos[7:0], val[9:8], val[7:0], XOR of bytes 1..4.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [8:0] pos,
                                            input logic [9:0] val);
    logic [7:0] b1, b2, b3, b4;
    logic [7:0] res;
    b1 = {7'b0, pos[8]};
    b2 = pos[7:0];
    b3 = {6'b0, val[9:8]};
    b4 = val[7:0];
    case (idx)
      3'd0:    res = SYNC_BYTE;
      3'd1:    res = b1;
      3'd2:    res = b2;
      3'd3:    res = b3;
      3'd4:    res = b4;
      3'd5:    res = b1 ^ b2 ^ b3 ^ b4;
      default: res = 8'h00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/max_result_tx_if.sv
// Bundle between the max latch stage and the result transmitter.
// latch is a 1-cycle strobe qualifying max_pos/max_val; there is no back-pressure, busy/overrun report status.
interface max_result_tx_if;
  import max_tx_pkg::*;

  logic       latch;
  logic [8:0] max_pos;
  logic [9:0] max_val;
  logic       tx;
  logic       busy;
  logic       overrun;
  state_t     state;

  modport master (
    output latch, max_pos, max_val,
    input  tx, busy, overrun, state
  );

  modport slave (
    input  latch, max_pos, max_val,
    output tx, busy, overrun, state
  );
endinterface

// File: rtl/max_result_tx.sv
// Sends each latched peak position/value as a 6-byte 8N1 UART frame.
// A one-deep pending buffer holds a result that arrives while a frame is on the line.
module max_result_tx
  import max_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input logic           clk,
  input logic           rst_n,
  max_result_tx_if.slave bus
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BYTE = 3'(FRAME_BYTES - 1);

  state_t        state_q;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    byte_idx;
  logic [8:0]    pos_q;
  logic [9:0]    val_q;
  logic [8:0]    pend_pos;
  logic [9:0]    pend_val;
  logic          pend_valid;
  logic          tx_q;
  logic          overrun_q;

  logic [7:0] cur_byte;
  logic [2:0] next_bit;
  logic       bit_end;
  logic       on_line;

  assign cur_byte = frame_byte(byte_idx, pos_q, val_q);
  assign next_bit = bit_idx + 3'd1;
  assign bit_end  = (bit_cnt == BIT_LAST);
  assign on_line  = (state_q == START) || (state_q == DATA) || (state_q == STOP);

  assign bus.tx      = tx_q;
  assign bus.busy    = (state_q != IDLE) | pend_valid;
  assign bus.overrun = overrun_q;
  assign bus.state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      byte_idx   <= 3'd0;
      pos_q      <= 9'd0;
      val_q      <= 10'd0;
      pend_pos   <= 9'd0;
      pend_val   <= 10'd0;
      pend_valid <= 1'b0;
      tx_q       <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.latch) begin
            pos_q    <= bus.max_pos;
            val_q    <= bus.max_val;
            byte_idx <= 3'd0;
            bit_cnt  <= '0;
            tx_q     <= 1'b0;
            state_q  <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= 3'd0;
            tx_q    <= cur_byte[0];
            state_q <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx <= next_bit;
              tx_q    <= cur_byte[next_bit];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (byte_idx < LAST_BYTE) begin
              byte_idx <= byte_idx + 3'd1;
              tx_q     <= 1'b0;
              state_q  <= START;
            end else begin
              state_q <= DONE;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          byte_idx <= 3'd0;
          bit_cnt  <= '0;
          // Older pending data goes out first; a coincident latch refills pending.
          if (pend_valid) begin
            pos_q   <= pend_pos;
            val_q   <= pend_val;
            tx_q    <= 1'b0;
            state_q <= START;
            if (bus.latch) begin
              pend_pos <= bus.max_pos;
              pend_val <= bus.max_val;
            end else begin
              pend_valid <= 1'b0;
            end
          end else if (bus.latch) begin
            pos_q   <= bus.max_pos;
            val_q   <= bus.max_val;
            tx_q    <= 1'b0;
            state_q <= START;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase

      if (bus.latch && on_line) begin
        pend_pos   <= bus.max_pos;
        pend_val   <= bus.max_val;
        pend_valid <= 1'b1;
        if (pend_valid) overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_max_result_tx.sv
// Directed bench for max_result_tx with CLKS_PER_BIT=4: expected frame bytes are queued
// when a latch is issued and a UART receiver process pops and compares each received byte.
module tb_max_result_tx;
  import max_tx_pkg::*;

  localparam int CPB = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   ovr_cnt;
  logic [7:0] exp_q[$];

  max_result_tx_if bus ();

  max_result_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (bus.overrun === 1'b1) ovr_cnt = ovr_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic push_frame(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3,
                            input logic [7:0] b4, input logic [7:0] b5);
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(b2);
    exp_q.push_back(b3);
    exp_q.push_back(b4);
    exp_q.push_back(b5);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_latch(input logic [8:0] pos, input logic [9:0] val);
    bus.latch   = 1'b1;
    bus.max_pos = pos;
    bus.max_val = val;
    tick();
    bus.latch = 1'b0;
  endtask

  // Waits (bounded) for busy to fall, optionally scrambling the data inputs each cycle.
  task automatic wait_idle(input bit scramble);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 2000) begin
      if (scramble) begin
        bus.max_pos = 9'($urandom_range(0, 511));
        bus.max_val = 10'($urandom_range(0, 1023));
      end
      tick();
      n++;
    end
    if (n >= 2000) check("busy_timeout", 32'(n), 32'd0);
  endtask

  // ---------------- monitor: UART receiver ----------------
  task automatic rx_wait(input int n, inout logic ab);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ab = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] rx;
    logic       stop;
    logic       ab;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.tx === 1'b0) begin
        ab = 1'b0;
        rx = 8'h00;
        rx_wait(CPB / 2, ab);
        for (int i = 0; i < 8; i++) begin
          rx_wait(CPB, ab);
          rx[i] = bus.tx;
        end
        rx_wait(CPB, ab);
        stop = bus.tx;
        if (!ab) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(rx), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(rx), 32'(e));
            check("stop_bit", 32'(stop), 32'd1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    int ov0;
    int bad;
    n_checks = 0;
    n_pass   = 0;
    ovr_cnt  = 0;
    rst_n       = 1'b0;
    bus.latch   = 1'b0;
    bus.max_pos = 9'd0;
    bus.max_val = 10'd0;
    repeat (3) tick();
    check("reset_tx", 32'(bus.tx), 32'd1);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);
    check("reset_state", 32'(bus.state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Inputs wiggle with no latch: line must stay idle.
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      bus.max_pos = 9'($urandom_range(0, 511));
      bus.max_val = 10'($urandom_range(0, 1023));
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("no_latch_idle", 32'(bad), 32'd0);

    // Single frame; data inputs scrambled during transmission.
    push_frame(8'h01, 8'hA3, 8'h02, 8'hF1, 8'h51);
    do_latch(9'h1A3, 10'h2F1);
    t0 = cyc;
    check("first_tx_low", 32'(bus.tx), 32'd0);
    check("first_busy", 32'(bus.busy), 32'd1);
    wait_idle(1'b1);
    check("single_busy_len", 32'(cyc - t0), 32'd241);
    repeat (10) tick();

    // Pending: second latch at +100 follows after only the DONE cycle.
    ov0 = ovr_cnt;
    push_frame(8'h01, 8'hA3, 8'h02, 8'hF1, 8'h51);
    push_frame(8'h00, 8'h05, 8'h03, 8'hFF, 8'hF9);
    do_latch(9'h1A3, 10'h2F1);
    t0 = cyc;
    repeat (99) tick();
    do_latch(9'h005, 10'h3FF);
    check("pending_busy", 32'(bus.busy), 32'd1);
    wait_idle(1'b0);
    check("pending_busy_len", 32'(cyc - t0), 32'd482);
    check("pending_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
    repeat (10) tick();

    // Overrun: +100 data is overwritten by +150 data.
    ov0 = ovr_cnt;
    push_frame(8'h01, 8'hA3, 8'h02, 8'hF1, 8'h51);
    push_frame(8'h00, 8'hF0, 8'h01, 8'h55, 8'hA4);
    do_latch(9'h1A3, 10'h2F1);
    t0 = cyc;
    repeat (99) tick();
    do_latch(9'h111, 10'h222);
    check("overrun_first_pending", 32'(bus.overrun), 32'd0);
    repeat (49) tick();
    do_latch(9'h0F0, 10'h155);
    check("overrun_pulse", 32'(bus.overrun), 32'd1);
    tick();
    check("overrun_clear", 32'(bus.overrun), 32'd0);
    wait_idle(1'b0);
    check("overrun_busy_len", 32'(cyc - t0), 32'd482);
    check("overrun_count", 32'(ovr_cnt - ov0), 32'd1);
    repeat (10) tick();

    // Latch exactly in DONE with nothing pending.
    ov0 = ovr_cnt;
    push_frame(8'h00, 8'h5A, 8'h01, 8'hC3, 8'h98);
    push_frame(8'h01, 8'hFF, 8'h00, 8'h00, 8'hFE);
    do_latch(9'h05A, 10'h1C3);
    t0 = cyc;
    repeat (240) tick();
    check("done_state", 32'(bus.state), 32'(DONE));
    do_latch(9'h1FF, 10'h000);
    check("done_restart_tx", 32'(bus.tx), 32'd0);
    check("done_restart_state", 32'(bus.state), 32'(START));
    wait_idle(1'b0);
    check("done_busy_len", 32'(cyc - t0), 32'd482);
    check("done_no_overrun", 32'(ovr_cnt - ov0), 32'd0);
    repeat (10) tick();
    check("queue_drained_mid", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame: asynchronous abort, then line idle until the next latch.
    push_frame(8'h01, 8'hA3, 8'h02, 8'hF1, 8'h51);
    do_latch(9'h1A3, 10'h2F1);
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("midreset_tx", 32'(bus.tx), 32'd1);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    check("post_reset_idle", 32'(bad), 32'd0);

    push_frame(8'h00, 8'h05, 8'h03, 8'hFF, 8'hF9);
    do_latch(9'h005, 10'h3FF);
    t0 = cyc;
    wait_idle(1'b0);
    check("post_reset_busy_len", 32'(cyc - t0), 32'd241);
    repeat (20) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
